keccak_sponge_ctrl: RTL and testbench

//  Parametrised sponge controller for the Keccak core; controls only, no state datapath.

---
 rtl/keccak_pkg.sv | 45 ++++
 rtl/keccak_round_ctr.sv | 33 +++
 rtl/keccak_sponge_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_keccak_sponge_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared types and constant tables for the Keccak sponge controller and its helpers.
// Pure declarations: no latency or flow-control behaviour of its own.
package keccak_pkg;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        ABSORB,
        PERM,
        SQUEEZE,
        DONE
    } state_e;

    localparam logic [2:0] MODE_MAX = 3'd5;

    localparam logic [4:0] RATE_LANES [6] = '{5'd18, 5'd17, 5'd13, 5'd9, 5'd21, 5'd17};
    localparam logic [3:0] SHA3_OUT_WORDS [4] = '{4'd4, 4'd4, 4'd6, 4'd8};

    localparam logic [7:0] DS_SHA3  = 8'h06;
    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END  = 8'h80;

    function automatic logic [4:0] rate_of(input logic [2:0] m);
        return (m <= MODE_MAX) ? RATE_LANES[m] : 5'd0;
    endfunction

    function automatic logic is_shake(input logic [2:0] m);
        return (m == MODE_SHAKE128) || (m == MODE_SHAKE256);
    endfunction

    function automatic logic [3:0] sha3_words_of(input logic [2:0] m);
        return SHA3_OUT_WORDS[m[1:0]];
    endfunction

endpackage

// File: rtl/keccak_round_ctr.sv
// Round counter for one permutation: clears outside PERM, steps while enabled, flags the last cycle.
// Counts NUM_ROUNDS/RPC cycles; no backpressure, the permutation never stalls.
module keccak_round_ctr #(
    parameter int NUM_ROUNDS = 24,
    parameter int RPC        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [4:0] rcnt,
    output logic       last
);

    localparam int CYCLES = NUM_ROUNDS / RPC;

    if (NUM_ROUNDS % RPC != 0) begin : g_bad_rpc
        $error("keccak_round_ctr: NUM_ROUNDS must be a multiple of RPC");
    end

    assign last = (rcnt == 5'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= 5'd0;
        end else if (clr) begin
            rcnt <= 5'd0;
        end else if (en) begin
            rcnt <= last ? 5'd0 : rcnt + 5'd1;
        end
    end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller: absorb with pad10*1, permutation sequencing, multi-block squeeze; no datapath.
// Block-to-absorb 1 cycle, perm NUM_ROUNDS/RPC cycles; in_ready only in FILL, squeeze word holds while !out_ready.
module keccak_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = 24,
    parameter int RPC        = 1,
    parameter int OLEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              msg_empty,
    input  logic [OLEN_W-1:0] out_len,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              buf_wr,
    output logic [4:0]        buf_idx,
    output logic              pad_ds,
    output logic              pad_end,
    output logic              absorb,
    output logic              perm_en,
    output logic [4:0]        round_idx,
    output logic [2:0]        mode_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] RPC5 = 5'(RPC);

    state_e            state_q, state_d;
    logic [2:0]        mode_r;
    logic [OLEN_W-1:0] olen_q;
    logic              latch_en;
    logic              final_q, final_d;
    logic              pad_pend_q, pad_pend_d;
    logic              pad_first_q, pad_first_d;
    logic [4:0]        wcnt_q, wcnt_d;
    logic [4:0]        scnt_q, scnt_d;
    logic [OLEN_W-1:0] tot_q, tot_d;

    logic [4:0]        rate_m1;
    logic [OLEN_W-1:0] sq;
    logic [OLEN_W:0]   tot_inc;
    logic [4:0]        rcnt;
    logic              rnd_last;

    keccak_round_ctr #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .RPC        (RPC)
    ) u_round_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != PERM),
        .en    (state_q == PERM),
        .rcnt  (rcnt),
        .last  (rnd_last)
    );

    assign rate_m1 = rate_of(mode_r) - 5'd1;
    assign sq      = is_shake(mode_r) ? olen_q : OLEN_W'(sha3_words_of(mode_r));
    // One extra bit so out_len of all ones terminates instead of wrapping.
    assign tot_inc = {1'b0, tot_q} + (OLEN_W+1)'(1);
    assign mode_q  = mode_r;
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_r      <= 3'd0;
            olen_q      <= '0;
            final_q     <= 1'b0;
            pad_pend_q  <= 1'b0;
            pad_first_q <= 1'b0;
            wcnt_q      <= 5'd0;
            scnt_q      <= 5'd0;
            tot_q       <= '0;
        end else begin
            state_q     <= state_d;
            final_q     <= final_d;
            pad_pend_q  <= pad_pend_d;
            pad_first_q <= pad_first_d;
            wcnt_q      <= wcnt_d;
            scnt_q      <= scnt_d;
            tot_q       <= tot_d;
            if (latch_en) begin
                mode_r <= mode;
                olen_q <= out_len;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        final_d     = final_q;
        pad_pend_d  = pad_pend_q;
        pad_first_d = pad_first_q;
        wcnt_d      = wcnt_q;
        scnt_d      = scnt_q;
        tot_d       = tot_q;
        latch_en    = 1'b0;
        in_ready    = 1'b0;
        buf_wr      = 1'b0;
        buf_idx     = 5'd0;
        pad_ds      = 1'b0;
        pad_end     = 1'b0;
        absorb      = 1'b0;
        perm_en     = 1'b0;
        round_idx   = 5'd0;
        out_valid   = 1'b0;
        out_idx     = 5'd0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (mode <= MODE_MAX)) begin
                    latch_en    = 1'b1;
                    final_d     = 1'b0;
                    pad_pend_d  = 1'b0;
                    pad_first_d = 1'b1;
                    wcnt_d      = 5'd0;
                    scnt_d      = 5'd0;
                    tot_d       = '0;
                    state_d     = msg_empty ? PAD : FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_wr  = 1'b1;
                    buf_idx = wcnt_q;
                    if (wcnt_q == rate_m1) begin
                        // A full final block leaves no room: padding goes into a block of its own.
                        wcnt_d     = 5'd0;
                        pad_pend_d = in_last;
                        state_d    = ABSORB;
                    end else begin
                        wcnt_d = wcnt_q + 5'd1;
                        if (in_last) begin
                            pad_first_d = 1'b1;
                            state_d     = PAD;
                        end
                    end
                end
            end
            PAD: begin
                buf_wr      = 1'b1;
                buf_idx     = wcnt_q;
                pad_ds      = pad_first_q;
                pad_first_d = 1'b0;
                if (wcnt_q == rate_m1) begin
                    pad_end    = 1'b1;
                    final_d    = 1'b1;
                    pad_pend_d = 1'b0;
                    wcnt_d     = 5'd0;
                    state_d    = ABSORB;
                end else begin
                    wcnt_d = wcnt_q + 5'd1;
                end
            end
            ABSORB: begin
                absorb  = 1'b1;
                state_d = PERM;
            end
            PERM: begin
                perm_en   = 1'b1;
                round_idx = rcnt * RPC5;
                if (rnd_last) begin
                    wcnt_d = 5'd0;
                    if (final_q) begin
                        state_d = (sq == '0) ? DONE : SQUEEZE;
                    end else if (pad_pend_q) begin
                        pad_first_d = 1'b1;
                        state_d     = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            SQUEEZE: begin
                out_valid = 1'b1;
                out_idx   = scnt_q;
                if (out_ready) begin
                    tot_d = tot_inc[OLEN_W-1:0];
                    if (tot_inc == {1'b0, sq}) begin
                        state_d = DONE;
                    end else if (scnt_q == rate_m1) begin
                        scnt_d  = 5'd0;
                        state_d = PERM;
                    end else begin
                        scnt_d = scnt_q + 5'd1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Scoreboard bench: a message-level sponge model queues expected events, a negedge monitor pops and compares.
module tb_keccak_sponge_ctrl;

    localparam int NR  = 24;
    localparam int RPC = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mode;
    logic        msg_empty;
    logic [15:0] out_len;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        buf_wr;
    logic [4:0]  buf_idx;
    logic        pad_ds;
    logic        pad_end;
    logic        absorb;
    logic        perm_en;
    logic [4:0]  round_idx;
    logic [2:0]  mode_q;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    keccak_sponge_ctrl #(.NUM_ROUNDS(NR), .RPC(RPC), .OLEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .msg_empty (msg_empty),
        .out_len   (out_len),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .buf_wr    (buf_wr),
        .buf_idx   (buf_idx),
        .pad_ds    (pad_ds),
        .pad_end   (pad_end),
        .absorb    (absorb),
        .perm_en   (perm_en),
        .round_idx (round_idx),
        .mode_q    (mode_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] kind;
        logic [4:0] idx;
        logic       ds;
        logic       pe;
    } evt_t;

    localparam logic [2:0] K_WR = 3'd1, K_ABS = 3'd2, K_PERM = 3'd3, K_OUT = 3'd4, K_DONE = 3'd5;

    int rate_tab [6] = '{18, 17, 13, 9, 21, 17};
    int sha_tab  [4] = '{4, 4, 6, 8};

    evt_t exp_q [$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    logic stall_req = 1'b0;

    logic [26:0] outs;
    assign outs = {in_ready, buf_wr, buf_idx, pad_ds, pad_end, absorb, perm_en, round_idx,
                   mode_q, out_valid, out_idx, busy, done};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [2:0] k, input int idx, input logic ds, input logic pe);
        evt_t e;
        e.kind = k;
        e.idx  = 5'(idx);
        e.ds   = ds;
        e.pe   = pe;
        exp_q.push_back(e);
    endfunction

    function automatic void push_perm();
        for (int k = 0; k < NR / RPC; k++) push(K_PERM, k * RPC, 1'b0, 1'b0);
    endfunction

    // Sponge behaviour for a whole message, expressed as lane/block arithmetic.
    function automatic void model_msg(input int m, input int n, input int olen);
        int r  = rate_tab[m];
        int sq = (m >= 4) ? olen : sha_tab[m];
        int p  = n % r;
        for (int i = 0; i < n; i++) begin
            push(K_WR, i % r, 1'b0, 1'b0);
            if (i % r == r - 1) begin
                push(K_ABS, 0, 1'b0, 1'b0);
                push_perm();
            end
        end
        for (int l = p; l < r; l++) push(K_WR, l, l == p, l == r - 1);
        push(K_ABS, 0, 1'b0, 1'b0);
        push_perm();
        for (int t = 0; t < sq; t++) begin
            if (t > 0 && t % r == 0) push_perm();
            push(K_OUT, t % r, 1'b0, 1'b0);
        end
        push(K_DONE, m, 1'b0, 1'b0);
    endfunction

    task automatic pop_cmp(input string nm, input evt_t act);
        evt_t e;
        if (exp_q.size() == 0) begin
            chk({"unexpected_", nm}, int'(act), 0);
        end else begin
            e = exp_q.pop_front();
            chk(nm, int'(act), int'(e));
        end
    endtask

    int   cyc = 0, last_wr = -100, last_abs = -100, last_acc = -100;
    logic prev_perm = 1'b0, prev_valid = 1'b0, hold_pend = 1'b0;
    logic [4:0] hold_idx = 5'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend  = 1'b0;
            prev_perm  = 1'b0;
            prev_valid = 1'b0;
            last_wr    = -100;
            last_abs   = -100;
            last_acc   = -100;
        end else begin
            cyc++;
            if (hold_pend) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_idx", int'(out_idx), int'(hold_idx));
            end
            hold_pend = out_valid && !out_ready;
            hold_idx  = out_idx;
            if (buf_wr) begin
                pop_cmp("wr", {K_WR, buf_idx, pad_ds, pad_end});
                last_wr = cyc;
            end
            if (absorb) begin
                pop_cmp("absorb", {K_ABS, 5'd0, 1'b0, 1'b0});
                chk("wr_to_absorb", cyc - last_wr, 1);
                last_abs = cyc;
            end
            if (perm_en) begin
                pop_cmp("perm", {K_PERM, round_idx, 1'b0, 1'b0});
                if (!prev_perm)
                    chk("perm_entry", int'((cyc - 1 == last_abs) || (cyc - 1 == last_acc)), 1);
            end
            if (out_valid && !prev_valid) chk("perm_to_out", int'(prev_perm), 1);
            if (out_valid && out_ready) begin
                pop_cmp("out", {K_OUT, out_idx, 1'b0, 1'b0});
                last_acc = cyc;
            end
            if (done) begin
                pop_cmp("done", {K_DONE, 2'b00, mode_q, 1'b0, 1'b0});
                done_cnt++;
            end
            prev_perm  = perm_en;
            prev_valid = out_valid;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && out_valid) begin
                out_ready = 1'b0;
                stall_req = 1'b0;
                repeat (4) @(posedge clk);
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int m, input int n, input int olen);
        start     = 1'b1;
        mode      = 3'(m);
        msg_empty = (n == 0);
        out_len   = 16'(olen);
        tick();
        start     = 1'b0;
        msg_empty = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            int budget = 200;
            logic acc = 1'b0;
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            while (!acc && budget > 0) begin
                @(negedge clk);
                acc = in_ready;
                tick();
                budget--;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!acc) begin
                chk("feed_timeout", 0, 1);
                return;
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic run_msg(input int m, input int n, input int olen, input logic inj);
        int d0 = done_cnt;
        int budget = 5000;
        model_msg(m, n, olen);
        issue_start(m, n, olen);
        feed(n);
        if (inj) begin
            start   = 1'b1;
            mode    = 3'd5;
            out_len = 16'd3;
            tick();
            start   = 1'b0;
        end
        while (done_cnt == d0 && budget > 0) begin
            tick();
            budget--;
        end
        if (done_cnt == d0) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
        end
        chk("idle_after_done", int'(busy), 0);
    endtask

    task automatic reset_mid_perm();
        int budget = 500;
        model_msg(1, 17, 0);
        issue_start(1, 17, 0);
        feed(17);
        while (!perm_en && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reached_perm", int'(perm_en), 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outs", int'(outs), 0);
        exp_q.delete();
        tick();
        chk("reset_mid_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 3'd0;
        msg_empty = 1'b0;
        out_len   = 16'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        repeat (3) tick();
        chk("reset_outs", int'(outs), 0);
        rst_n = 1'b1;
        tick();

        start = 1'b1;
        mode  = 3'd6;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("mode6_busy", int'(busy), 0);
        chk("mode6_in_ready", int'(in_ready), 0);

        stall_req = 1'b1;
        run_msg(1, 3, 0, 1'b0);
        run_msg(1, 17, 0, 1'b0);
        run_msg(3, 8, 0, 1'b0);
        run_msg(0, 0, 0, 1'b0);
        run_msg(4, 5, 25, 1'b1);
        reset_mid_perm();
        run_msg(5, 0, 0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            int m = int'($urandom_range(0, 5));
            int n = int'($urandom_range(0, 44));
            int o = int'($urandom_range(0, 49));
            run_msg(m, n, o, 1'($urandom_range(0, 1)));
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
